// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register: two-entry skid buffer feeding the writeback 2:1 mux.
// Define MEM_WB_BUBBLE_COUNT_EN to add the bubble_count output.
module mem_wb_skid_reg #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic              in_mem_to_reg,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic              out_select,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_reg_write
`ifdef MEM_WB_BUBBLE_COUNT_EN
  ,
  output logic [15:0]       bubble_count
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic              sel;
    logic [ADDR_W-1:0] rd;
    logic              rw;
  } wb_t;

  wb_t  main_q, main_d;
  wb_t  skid_q, skid_d;
  wb_t  in_pl;
  logic main_v_q, main_v_d;
  logic skid_v_q, skid_v_d;
  logic rdy_q, rdy_d;
  logic accept, pop;
  logic mv, ld_main, ld_skid, drain;

  assign in_pl = '{alu: in_alu_result,
                   mem: in_mem_data,
                   sel: in_mem_to_reg,
                   rd:  in_rd,
                   rw:  in_reg_write};

  assign accept = in_valid & rdy_q;
  assign pop    = main_v_q & out_ready;

  // rdy_q mirrors !skid_v_q, so a skid move never coincides with accept
  assign mv      = pop & skid_v_q;
  assign ld_main = accept & (~main_v_q | pop);
  assign ld_skid = accept & main_v_q & ~pop;
  assign drain   = pop & ~skid_v_q & ~accept;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      unique case (1'b1)
        mv: begin
          main_d   = skid_q;
          skid_v_d = 1'b0;
        end
        ld_main: begin
          main_d   = in_pl;
          main_v_d = 1'b1;
        end
        ld_skid: begin
          skid_d   = in_pl;
          skid_v_d = 1'b1;
        end
        drain: main_v_d = 1'b0;
        default: ;
      endcase
    end
    rdy_d = ~skid_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
    end
  end

  assign in_ready      = rdy_q;
  assign out_valid     = main_v_q;
  assign out_data0     = main_q.alu;
  assign out_data1     = main_q.mem;
  assign out_select    = main_q.sel;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_q.rw & main_v_q;

`ifdef MEM_WB_BUBBLE_COUNT_EN
  logic [15:0] bub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bub_q <= '0;
    end else if (out_ready && !main_v_q && bub_q != 16'hFFFF) begin
      bub_q <= bub_q + 16'd1;
    end
  end

  assign bubble_count = bub_q;
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: vector table plus FIFO scoreboard.
// Also checks bubble_count when MEM_WB_BUBBLE_COUNT_EN is defined.
module tb_mem_wb_skid_reg;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] mem;
    logic        sel;
    logic [3:0]  rd;
    logic        rw;
  } pl_t;

  typedef struct {
    logic        v;
    logic        ordy;
    logic        fl;
    pl_t         p;
    logic        eov;
    logic        eir;
    logic [15:0] ed0;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_alu_result = '0;
  logic [15:0] in_mem_data = '0;
  logic        in_mem_to_reg = 1'b0;
  logic [3:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data0;
  logic [15:0] out_data1;
  logic        out_select;
  logic [3:0]  out_rd;
  logic        out_reg_write;
`ifdef MEM_WB_BUBBLE_COUNT_EN
  logic [15:0] bubble_count;
`endif

  mem_wb_skid_reg #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_result (in_alu_result),
    .in_mem_data   (in_mem_data),
    .in_mem_to_reg (in_mem_to_reg),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data0     (out_data0),
    .out_data1     (out_data1),
    .out_select    (out_select),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write)
`ifdef MEM_WB_BUBBLE_COUNT_EN
    ,
    .bubble_count  (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  pl_t  sb[$];
  int   mbub = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic ordy,
                              input logic fl, input logic [15:0] alu,
                              input logic [15:0] mem, input logic sel,
                              input logic [3:0] rd, input logic rw,
                              input logic eov, input logic eir,
                              input logic [15:0] ed0);
    vec_t r;
    r.v = v; r.ordy = ordy; r.fl = fl;
    r.p = '{alu: alu, mem: mem, sel: sel, rd: rd, rw: rw};
    r.eov = eov; r.eir = eir; r.ed0 = ed0;
    return r;
  endfunction

  task automatic check_sb(input string tag);
    chk({tag, " sb_valid"}, 32'(out_valid), 32'(sb.size() > 0));
    chk({tag, " sb_ready"}, 32'(in_ready), 32'(sb.size() < 2));
    if (sb.size() > 0) begin
      chk({tag, " d0"}, 32'(out_data0), 32'(sb[0].alu));
      chk({tag, " d1"}, 32'(out_data1), 32'(sb[0].mem));
      chk({tag, " sel"}, 32'(out_select), 32'(sb[0].sel));
      chk({tag, " rd"}, 32'(out_rd), 32'(sb[0].rd));
      chk({tag, " rw"}, 32'(out_reg_write), 32'(sb[0].rw));
    end else begin
      chk({tag, " rw_idle"}, 32'(out_reg_write), 32'd0);
    end
`ifdef MEM_WB_BUBBLE_COUNT_EN
    chk({tag, " bubbles"}, 32'(bubble_count), 32'(mbub));
`endif
  endtask

  task automatic apply(input vec_t r, input string tag);
    logic acc, pp, bub;
    @(negedge clk);
    in_valid      = r.v;
    out_ready     = r.ordy;
    flush         = r.fl;
    in_alu_result = r.p.alu;
    in_mem_data   = r.p.mem;
    in_mem_to_reg = r.p.sel;
    in_rd         = r.p.rd;
    in_reg_write  = r.p.rw;
    acc = r.v && (sb.size() < 2);
    pp  = r.ordy && (sb.size() > 0);
    bub = r.ordy && (sb.size() == 0);
    @(posedge clk);
    #1;
    if (r.fl) begin
      sb.delete();
    end else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back(r.p);
    end
    if (bub && mbub != 32'hFFFF) mbub++;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(r.eov));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(r.eir));
    if (r.eov) chk({tag, " head"}, 32'(out_data0), 32'(r.ed0));
    check_sb(tag);
  endtask

  initial begin
    // bubble count while empty, then flush with writeback stalled
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    // single pass
    tbl.push_back(mk(1, 1, 0, 16'hAAAA, 16'hBBBB, 1, 4'h3, 1,
                     1, 1, 16'hAAAA));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // stall fill then drain
    tbl.push_back(mk(1, 0, 0, 16'h0001, 16'h0101, 0, 4'h1, 1,
                     1, 1, 16'h0001));
    tbl.push_back(mk(1, 0, 0, 16'h0002, 16'h0102, 1, 4'h2, 0,
                     1, 0, 16'h0001));
    tbl.push_back(mk(1, 1, 0, 16'hDEAD, 16'hDEAD, 1, 4'hF, 1,
                     1, 1, 16'h0002));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // streaming 0..7
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 1, 0, 16'(i), 16'(i + 256), i[0], 4'(i),
                       i[1], 1, 1, 16'(i)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // flush while full, with a new instruction presented
    tbl.push_back(mk(1, 0, 0, 16'h0010, 16'h1010, 0, 4'h5, 1,
                     1, 1, 16'h0010));
    tbl.push_back(mk(1, 0, 0, 16'h0011, 16'h1011, 1, 4'h6, 1,
                     1, 0, 16'h0010));
    tbl.push_back(mk(1, 0, 1, 16'h0012, 16'h1012, 0, 4'h7, 1,
                     0, 1, 0));
    // flush overriding accept and pop in the same cycle
    tbl.push_back(mk(1, 0, 0, 16'h0020, 16'h1020, 0, 4'h8, 1,
                     1, 1, 16'h0020));
    tbl.push_back(mk(1, 1, 1, 16'h0021, 16'h1021, 1, 4'h9, 1,
                     0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst data0", 32'(out_data0), 32'd0);
    chk("rst data1", 32'(out_data1), 32'd0);
    chk("rst sel_rd_rw", {29'd0, out_select, out_reg_write,
        (out_rd != 4'd0)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
`ifdef MEM_WB_BUBBLE_COUNT_EN
      if (i == 5) chk("bubble after flush", 32'(bubble_count), 32'd5);
`endif
    end

    // asynchronous reset in the middle of a cycle while full
    apply(mk(1, 0, 0, 16'h0030, 16'h1030, 1, 4'hA, 1, 1, 1, 16'h0030),
          "pre_rst0");
    apply(mk(1, 0, 0, 16'h0031, 16'h1031, 0, 4'hB, 1, 1, 0, 16'h0030),
          "pre_rst1");
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    mbub = 0;
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst in_ready", 32'(in_ready), 32'd1);
    chk("arst data0", 32'(out_data0), 32'd0);
    chk("arst data1", 32'(out_data1), 32'd0);
    chk("arst sel_rd_rw", {29'd0, out_select, out_reg_write,
        (out_rd != 4'd0)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), $sformatf("post%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
